// File: rtl/mem_bus_controller.sv
// Data-memory bus controller: steers CPU byte/half/word requests onto a
// 32-bit word-addressed BRAM. Optional MEM_BUS_CONTROLLER_STATS_EN adds counters.
module mem_bus_controller #(
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 2,
  parameter int BRAM_AW      = $clog2(DEPTH_WORDS)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               dispatch_read,
  input  logic               dispatch_write,
  input  logic [31:0]        addr,
  input  logic [1:0]         mem_width,
  input  logic [31:0]        write_data,
  output logic               busy,
  output logic [31:0]        read_data,
  output logic               err,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic               bram_en,
  output logic [3:0]         bram_we,
  output logic [31:0]        bram_wdata,
`ifdef MEM_BUS_CONTROLLER_STATS_EN
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count,
`endif
  input  logic [31:0]        bram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE
  } state_t;

  state_t             state, state_d;
  logic [2:0]         cnt, cnt_d;
  logic [1:0]         lane, lane_d;
  logic [1:0]         width, width_d;
  logic [31:0]        read_data_d;
  logic               err_d;
  logic               en_d;
  logic [3:0]         we_d;
  logic [BRAM_AW-1:0] addr_d;
  logic [31:0]        wdata_d;
  logic [31:0]        mask;
  logic               dispatch;
  logic               fault;
  logic               accept_rd;
  logic               accept_wr;

  assign dispatch = dispatch_read | dispatch_write;
  assign busy     = (state != IDLE) | dispatch;

  // Request legality: width code, alignment, range, and conflicting strobes.
  always_comb begin
    fault = 1'b0;
    if (mem_width == 2'd3) fault = 1'b1;
    if (mem_width == 2'd1 && addr[0]) fault = 1'b1;
    if (mem_width == 2'd2 && addr[1:0] != 2'b00) fault = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) fault = 1'b1;
    if (dispatch_read && dispatch_write) fault = 1'b1;
  end

  assign accept_rd = (state == IDLE) & dispatch_read & ~fault;
  assign accept_wr = (state == IDLE) & dispatch_write & ~fault;

  // Load result mask for the latched access width.
  always_comb begin
    mask = 32'hFFFF_FFFF;
    unique case (width)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    lane_d      = lane;
    width_d     = width;
    read_data_d = read_data;
    err_d       = err;
    en_d        = bram_en;
    we_d        = bram_we;
    addr_d      = bram_addr;
    wdata_d     = bram_wdata;
    unique case (state)
      IDLE: begin
        if (dispatch && fault) begin
          err_d       = 1'b1;
          read_data_d = 32'h0;
        end else if (accept_rd) begin
          state_d = READ_WAIT;
          en_d    = 1'b1;
          addr_d  = addr[BRAM_AW+1:2];
          cnt_d   = 3'(READ_LATENCY);
          lane_d  = addr[1:0];
          width_d = mem_width;
        end else if (accept_wr) begin
          state_d = WRITE;
          en_d    = 1'b1;
          addr_d  = addr[BRAM_AW+1:2];
          wdata_d = write_data << {addr[1:0], 3'b000};
          unique case (mem_width)
            2'd0:    we_d = 4'b0001 << addr[1:0];
            2'd1:    we_d = 4'b0011 << addr[1:0];
            default: we_d = 4'b1111;
          endcase
        end
      end
      READ_WAIT: begin
        if (dispatch) err_d = 1'b1;
        if (cnt == 3'd0) begin
          read_data_d = (bram_rdata >> {lane, 3'b000}) & mask;
          state_d     = IDLE;
          en_d        = 1'b0;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      WRITE: begin
        if (dispatch) err_d = 1'b1;
        we_d    = 4'b0000;
        en_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      lane       <= 2'd0;
      width      <= 2'd0;
      read_data  <= 32'h0;
      err        <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 4'b0000;
      bram_addr  <= '0;
      bram_wdata <= 32'h0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      lane       <= lane_d;
      width      <= width_d;
      read_data  <= read_data_d;
      err        <= err_d;
      bram_en    <= en_d;
      bram_we    <= we_d;
      bram_addr  <= addr_d;
      bram_wdata <= wdata_d;
    end
  end

`ifdef MEM_BUS_CONTROLLER_STATS_EN
  // Accepted-access counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_count <= 32'h0;
      wr_count <= 32'h0;
    end else begin
      if (accept_rd) rd_count <= rd_count + 32'h1;
      if (accept_wr) wr_count <= wr_count + 32'h1;
    end
  end
`endif

endmodule
